axi_camera_frame_writer: RTL and testbench
==========================================

AXI_CAMERA_FRAME_WRITER -- requirements
Module: axi_camera_frame_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning AXI write data width in bits; legal values are 32, 64 and 128.
REQ-002 The block SHALL have parameter BURST_LEN, default 16, meaning beats per burst; legal range is 1..256.
REQ-003 The block SHALL have parameter NUM_BURSTS, default 4, meaning bursts per frame; legal range is 1..65535.
REQ-004 The block SHALL have these ports; one clock and a synchronous active-low reset, ACLK and ARESETn:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- start  in  1  frame start request
- start_addr  in  32  frame base byte address, latched on start
- pix_data  in  DATA_W  pixel stream data
- pix_valid  in  1  pixel stream valid
- pix_ready  out  1  pixel stream ready
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse
- err  out  1  sticky: non-OKAY BRESP seen this frame
- AWADDR  out  32  burst address
- AWLEN  out  8  BURST_LEN-1
- AWSIZE  out  3  log2(DATA_W/8)
- AWBURST  out  2  constant 2'b01 (INCR)
- AWVALID / AWREADY  out / in  1  AW handshake
- WDATA  out  DATA_W  write data
- WSTRB  out  DATA_W/8  all ones
- WVALID / WREADY  out / in  1  W handshake
- WLAST  out  1  last beat of burst
- BRESP  in  2  write response
- BVALID / BREADY  in / out  1  B handshake

Function
REQ-005 FSM states SHALL be IDLE, ADDR, DATA, RESP and FIN.
REQ-006 IDLE transitions:
- start=1 -> ADDR; latch start_addr; clear burst counter; clear err.
- start is ignored in every state other than IDLE.
REQ-007 ADDR:
- AWVALID=1, held with AWADDR stable until the AWREADY edge.
- On AWVALID&&AWREADY -> DATA; beat counter=0.
REQ-008 AWADDR SHALL equal latched start_addr + burst_index*BURST_LEN*(DATA_W/8), modulo 2^32.
REQ-009 DATA:
- WDATA=pix_data, WVALID=pix_valid, pix_ready=WREADY (combinational pass-through).
- Outside DATA, WVALID=0 and pix_ready=0.
REQ-010 A beat SHALL complete on WVALID&&WREADY, incrementing the beat counter.
REQ-011 WLAST SHALL equal 1 exactly when WVALID=1 and beat counter==BURST_LEN-1; on that beat's handshake -> RESP.
REQ-012 RESP:
- BREADY=1.
- On BVALID: BRESP!=2'b00 sets err.
- If burst_index==NUM_BURSTS-1 -> FIN; otherwise increment burst_index -> ADDR.
REQ-013 Only one burst SHALL be outstanding; AWVALID is never asserted again before the prior BVALID is accepted.
REQ-014 FIN: done=1 for exactly one cycle -> IDLE; err holds its value until the next accepted start.
REQ-015 busy SHALL be 1 in ADDR, DATA, RESP and FIN, and 0 in IDLE.
REQ-016 Zero-wait case: with AWREADY, WREADY, pix_valid and BVALID held high, one burst SHALL take exactly BURST_LEN+2 cycles (1 ADDR, BURST_LEN DATA, 1 RESP).
REQ-017 BURST_LEN=1: the single beat SHALL carry WLAST=1.
REQ-018 The block SHALL not check 4 KB boundary crossing or address alignment; both are caller responsibility.

Reset
REQ-019 With ARESETn=0 at a rising ACLK edge, state SHALL become IDLE and all counters clear.
REQ-020 After reset, these outputs SHALL be 0: AWVALID, WVALID, WLAST, BREADY, pix_ready, busy, done, err, AWADDR and WDATA.
REQ-021 Reset mid-frame SHALL abandon the frame without a done pulse; the first cycle after release is IDLE.

Verification
REQ-022 Defaults, start_addr=0x1000, all ready/valid high:
- 4 bursts at AWADDR 0x1000, 0x1040, 0x1080, 0x10C0.
- 16 beats each, WLAST on beats 15/31/47/63.
- done at cycle 73 after start; err=0.
REQ-023 Backpressure:
- AWREADY delayed 3 cycles -> AWVALID and AWADDR held stable.
- WREADY toggling 1/0 -> beat count and WDATA order preserved.
- pix_valid gaps -> no extra beats.
REQ-024 BRESP=2'b10 on burst 2 of 4:
- Frame completes, err=1 from then through done.
- Next start clears err.
REQ-025 ARESETn=0 mid-burst at beat 7 -> all outputs 0 next edge; no done; a new start runs a full frame correctly.
REQ-026 Parameter corners:
- BURST_LEN=1, NUM_BURSTS=1, DATA_W=128: single beat with WLAST=1, AWSIZE=3'd4, WSTRB=16'hFFFF.
- start_addr=0xFFFF_FFC0 with defaults: address wraps to 0x0000_0000 on burst 1.
- start asserted while busy is ignored.

Source files
------------

// File: rtl/axi_camera_frame_writer.sv
// Camera frame writer: streams NUM_BURSTS fixed-length AXI4 INCR write bursts of pixel
// data per frame from a valid/ready pixel stream, keeping one burst outstanding at a time.
module axi_camera_frame_writer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned NUM_BURSTS = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WVALID,
    input  logic                WREADY,
    output logic                WLAST,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * STRB_W);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] burst_q, burst_d;
    logic        err_q, err_d;

    assign AWLEN   = LAST_BEAT;
    assign AWSIZE  = 3'($clog2(STRB_W));
    assign AWBURST = 2'b01;
    assign WSTRB   = {STRB_W{1'b1}};
    assign AWADDR  = addr_q;
    assign err     = err_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake decode; W channel is a straight pass-through in DATA.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        err_d     = err_q;
        AWVALID   = 1'b0;
        WVALID    = 1'b0;
        WDATA     = '0;
        WLAST     = 1'b0;
        pix_ready = 1'b0;
        BREADY    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ADDR;
                    addr_d  = start_addr;
                    burst_d = '0;
                    err_d   = 1'b0;
                end
            end
            ADDR: begin
                AWVALID = 1'b1;
                if (AWREADY) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                WVALID    = pix_valid;
                WDATA     = pix_data;
                pix_ready = WREADY;
                WLAST     = pix_valid && (beat_q == LAST_BEAT);
                if (pix_valid && WREADY) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    if (BRESP != 2'b00) err_d = 1'b1;
                    if (burst_q == LAST_BURST) begin
                        state_d = FIN;
                    end else begin
                        // Address advances by whole bursts and wraps modulo 2^32.
                        burst_d = burst_q + 16'd1;
                        addr_d  = addr_q + BURST_BYTES;
                        state_d = ADDR;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_camera_frame_writer.sv
// Scoreboard bench for axi_camera_frame_writer: randomized frames and channel stalls
// against a queue-based frame model, plus a 128-bit single-beat corner instance.
module tb_axi_camera_frame_writer;
    localparam int DW      = 32;
    localparam int BL      = 16;
    localparam int NB      = 4;
    localparam int BYTES   = BL * (DW / 8);
    localparam int TIMEOUT = 4000;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } wbeat_t;

    typedef struct {
        logic err;
        int   lat;
    } done_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   start_addr;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy, done, err;
    logic [31:0]   AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWVALID, AWREADY;
    logic [DW-1:0] WDATA;
    logic [DW/8-1:0] WSTRB;
    logic          WVALID, WREADY, WLAST;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;

    logic          start1;
    logic [31:0]   start_addr1;
    logic [127:0]  pix_data1;
    logic          pix_valid1, pix_ready1;
    logic          busy1, done1, err1;
    logic [31:0]   AWADDR1;
    logic [7:0]    AWLEN1;
    logic [2:0]    AWSIZE1;
    logic [1:0]    AWBURST1;
    logic          AWVALID1, AWREADY1;
    logic [127:0]  WDATA1;
    logic [15:0]   WSTRB1;
    logic          WVALID1, WREADY1, WLAST1;
    logic [1:0]    BRESP1;
    logic          BVALID1, BREADY1;

    int checks;
    int failures;

    logic [31:0]   exp_aw_q[$];
    wbeat_t        exp_w_q[$];
    done_t         exp_done_q[$];
    logic [DW-1:0] src_q[$];

    int         aw_delay;
    int         wr_mode;
    int         pv_mode;
    int         b_mode;
    logic [1:0] bresp_plan[NB];
    int         b_count;
    bit         mon_en;
    int         w_seen;
    int         done_seen;

    axi_camera_frame_writer #(.DATA_W(DW), .BURST_LEN(BL), .NUM_BURSTS(NB)) u_dut (
        .ACLK(clk), .ARESETn(rst_n), .start(start), .start_addr(start_addr),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done), .err(err),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    axi_camera_frame_writer #(.DATA_W(128), .BURST_LEN(1), .NUM_BURSTS(1)) u_dut1 (
        .ACLK(clk), .ARESETn(rst_n), .start(start1), .start_addr(start_addr1),
        .pix_data(pix_data1), .pix_valid(pix_valid1), .pix_ready(pix_ready1),
        .busy(busy1), .done(done1), .err(err1),
        .AWADDR(AWADDR1), .AWLEN(AWLEN1), .AWSIZE(AWSIZE1), .AWBURST(AWBURST1),
        .AWVALID(AWVALID1), .AWREADY(AWREADY1),
        .WDATA(WDATA1), .WSTRB(WSTRB1), .WVALID(WVALID1), .WREADY(WREADY1), .WLAST(WLAST1),
        .BRESP(BRESP1), .BVALID(BVALID1), .BREADY(BREADY1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // AW slave: AWREADY rises only after AWVALID has been seen for aw_delay cycles.
    initial begin : aw_resp
        int cnt;
        cnt = 0;
        AWREADY = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (AWVALID) begin
                cnt++;
                AWREADY = (cnt > aw_delay);
            end else begin
                cnt = 0;
                AWREADY = (aw_delay == 0);
            end
        end
    end

    initial begin : w_resp
        bit tog;
        tog = 1'b0;
        WREADY = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (wr_mode)
                0: WREADY = 1'b1;
                1: begin tog = ~tog; WREADY = tog; end
                default: WREADY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Pixel source: offers src_q in order, holding each word until it is accepted.
    initial begin : pix_src
        bit hs;
        pix_valid = 1'b0;
        pix_data  = '0;
        forever begin
            @(negedge clk);
            hs = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() == 0) begin
                pix_valid = 1'b0;
            end else if (pix_valid && !hs) begin
                pix_data = src_q[0];
            end else begin
                pix_valid = (pv_mode == 0) || ($urandom_range(0, 2) != 0);
                pix_data  = src_q[0];
            end
        end
    end

    initial begin : b_resp
        bit hs;
        BVALID = 1'b1;
        BRESP  = 2'b00;
        forever begin
            @(negedge clk);
            hs = BVALID && BREADY;
            @(posedge clk); #1;
            if (hs) b_count++;
            BVALID = (b_mode == 0) || ($urandom_range(0, 2) == 0);
            BRESP  = (b_count < NB) ? bresp_plan[b_count] : 2'b00;
        end
    end

    // Monitor: pops the scoreboard on every AW/W handshake and done pulse.
    initial begin : monitor
        bit          aw_wait;
        logic [31:0] aw_prev;
        bit          busy_prev;
        bit          err_model;
        int          outstanding;
        int          cyc;
        int          busy_start;
        done_t       d;
        wbeat_t      w;
        logic [31:0] a;
        aw_wait = 0; aw_prev = '0; busy_prev = 0; err_model = 0;
        outstanding = 0; cyc = 0; busy_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                aw_wait = 0; busy_prev = 0; err_model = 0; outstanding = 0;
                continue;
            end
            if (busy && !busy_prev) begin
                busy_start = cyc;
                err_model  = 0;
                w_seen     = 0;
            end
            chk("err_sticky", err, err_model);
            if (aw_wait) chk("aw_hold", {AWVALID, AWADDR}, {1'b1, aw_prev});
            if (AWVALID && AWREADY) begin
                chk("aw_one_outstanding", outstanding, 0);
                if (exp_aw_q.size() == 0) begin
                    chk("aw_extra", AWVALID, 0);
                end else begin
                    a = exp_aw_q.pop_front();
                    chk("awaddr", AWADDR, a);
                    chk("aw_attr", {AWLEN, AWSIZE, AWBURST}, {8'(BL - 1), 3'd2, 2'b01});
                end
                outstanding++;
            end
            aw_wait = AWVALID && !AWREADY;
            aw_prev = AWADDR;
            if (WVALID && WREADY) begin
                if (exp_w_q.size() == 0) begin
                    chk("w_extra", WVALID, 0);
                end else begin
                    w = exp_w_q.pop_front();
                    chk("wdata", WDATA, w.data);
                    chk("wlast", WLAST, w.last);
                    chk("wstrb", WSTRB, 4'hF);
                end
                w_seen++;
            end else if (WVALID && exp_w_q.size() > 0) begin
                chk("wlast_stalled", WLAST, exp_w_q[0].last);
            end
            if (BVALID && BREADY) begin
                outstanding--;
                if (BRESP != 2'b00) err_model = 1;
            end
            if (done) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    chk("done_extra", done, 0);
                end else begin
                    d = exp_done_q.pop_front();
                    chk("done_err", err, d.err);
                    chk("frame_beats_left", exp_w_q.size() + exp_aw_q.size(), 0);
                    if (d.lat >= 0) chk("done_latency", cyc - busy_start, d.lat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    // Frame model: AW addresses, beat data/last and final err derived from the frame rules.
    task automatic launch_frame(input logic [31:0] base, input int lat);
        done_t  d;
        wbeat_t w;
        bit     e;
        wait_idle();
        e = 0;
        for (int i = 0; i < NB; i++) begin
            exp_aw_q.push_back(32'(64'(base) + 64'(i) * 64'(BYTES)));
            e |= (bresp_plan[i] != 2'b00);
        end
        for (int k = 0; k < NB * BL; k++) begin
            w.data = $urandom;
            w.last = ((k % BL) == BL - 1);
            exp_w_q.push_back(w);
            src_q.push_back(w.data);
        end
        d.err = e;
        d.lat = lat;
        exp_done_q.push_back(d);
        b_count = 0;
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        start_addr = $urandom;
    endtask

    task automatic wait_done();
        int n0;
        int n;
        n0 = done_seen;
        n = 0;
        while (done_seen == n0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == n0) chk("done_timeout", done_seen, n0 + 1);
    endtask

    task automatic zero_wait();
        aw_delay = 0; wr_mode = 0; pv_mode = 0; b_mode = 0;
        for (int i = 0; i < NB; i++) bresp_plan[i] = 2'b00;
    endtask

    initial begin : stim
        int          n;
        int          cyc1;
        int          beats1;
        logic [127:0] d1;
        bit          zw;
        checks = 0; failures = 0; mon_en = 0; w_seen = 0; done_seen = 0; b_count = 0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0;
        start1 = 1'b0; start_addr1 = '0; pix_data1 = '0; pix_valid1 = 1'b0;
        AWREADY1 = 1'b1; WREADY1 = 1'b1; BVALID1 = 1'b1; BRESP1 = 2'b00;
        zero_wait();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {AWVALID, WVALID, WLAST, BREADY, pix_ready, busy, done, err, AWADDR, WDATA}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Zero-wait frame: 4 x 18 cycles from first busy cycle to done.
        launch_frame(32'h0000_1000, NB * (BL + 2));
        wait_done();

        // Backpressure on AW, W and the pixel stream.
        aw_delay = 3; wr_mode = 1; pv_mode = 1;
        launch_frame(32'h0000_2000, -1);
        wait_done();

        // SLVERR on the second burst, then a clean frame clears err.
        zero_wait();
        bresp_plan[1] = 2'b10;
        launch_frame(32'h0000_4000, NB * (BL + 2));
        wait_done();
        zero_wait();
        launch_frame(32'h0000_5000, NB * (BL + 2));
        wait_done();

        // Address wrap past 2^32 on the second burst.
        launch_frame(32'hFFFF_FFC0, NB * (BL + 2));
        wait_done();

        // start while busy must be ignored.
        launch_frame(32'h0000_6000, NB * (BL + 2));
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = 32'h0000_9000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_restart", busy, 0);
        end

        // Reset mid-burst: everything drops, no done, then a full frame runs cleanly.
        launch_frame(32'h0000_3000, -1);
        n = 0;
        while (w_seen < 7 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (w_seen < 7) chk("reset_beat_timeout", w_seen, 7);
        rst_n = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("midreset_outputs", {AWVALID, WVALID, WLAST, BREADY, pix_ready, busy, done, err, AWADDR, WDATA}, '0);
        exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete(); src_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {busy, done}, 0);
        mon_en = 1'b1;
        launch_frame(32'h0000_7000, NB * (BL + 2));
        wait_done();

        // Randomized frames and channel behaviour.
        for (int f = 0; f < 6; f++) begin
            aw_delay = $urandom_range(0, 3);
            wr_mode  = $urandom_range(0, 2);
            pv_mode  = $urandom_range(0, 1);
            b_mode   = $urandom_range(0, 1);
            for (int i = 0; i < NB; i++)
                bresp_plan[i] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            zw = (aw_delay == 0) && (wr_mode == 0) && (pv_mode == 0) && (b_mode == 0);
            launch_frame($urandom, zw ? NB * (BL + 2) : -1);
            wait_done();
        end
        zero_wait();

        // 128-bit, single-beat, single-burst instance.
        d1 = {$urandom, $urandom, $urandom, $urandom};
        pix_data1 = d1;
        pix_valid1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b1;
        start_addr1 = 32'h0001_0000;
        @(posedge clk); #1;
        start1 = 1'b0;
        start_addr1 = '0;
        chk("c1_attr", {AWLEN1, AWSIZE1, AWBURST1, WSTRB1}, {8'd0, 3'd4, 2'b01, 16'hFFFF});
        cyc1 = 0;
        beats1 = 0;
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge clk);
            n++;
            if (AWVALID1 && AWREADY1) chk("c1_awaddr", AWADDR1, 32'h0001_0000);
            if (WVALID1 && WREADY1) begin
                beats1++;
                chk("c1_wdata", WDATA1, d1);
                chk("c1_wlast", WLAST1, 1);
            end
            if (busy1 && cyc1 == 0) cyc1 = n;
        end
        if (!done1) chk("c1_done_timeout", done1, 1);
        chk("c1_beats", beats1, 1);
        chk("c1_latency", n - cyc1, 3);
        chk("c1_err", err1, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
